// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the single-ALU MIPS-subset datapath.
// It sequences each instruction through fetch, decode, execute, memory and
// write-back. Controls are Moore decodes of the current state. The exceptions
// are the strobes gated by memAck and the branch PC write gated by zero.
// A memory access that is not acknowledged within TIMEOUT cycles is dropped
// for one cycle (memErr) and the machine returns to FETCH.
module mc_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       memAck,
  output logic       memReq,
  output logic       memWr,
  output logic       iorD,
  output logic       irWr,
  output logic       pcWr,
  output logic [1:0] pcSrc,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       extOp,
  output logic [2:0] aluCtr,
  output logic       regWr,
  output logic       regDst,
  output logic       memToReg,
  output logic       instrDone,
  output logic       illegal,
  output logic       memErr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_ALUWB  = 4'd4;
  localparam logic [3:0] S_MEMADR = 4'd5;
  localparam logic [3:0] S_MEMRD  = 4'd6;
  localparam logic [3:0] S_MEMWB  = 4'd7;
  localparam logic [3:0] S_MEMWR  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLT  = 6'b101010;

  logic [3:0]    state_reg;
  logic [3:0]    state_next;
  logic [CW-1:0] wait_cnt_reg;
  logic          ovf_reg;

  logic is_rtype;
  logic is_ori;
  logic is_addi;
  logic is_lui;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_j;
  logic req_state;
  logic timeout;

  // Instruction class decode from the IR fields (stable from DECODE onward).
  assign is_rtype = (op == OP_RTYPE) &&
                    ((funct == F_ADDU) || (funct == F_SUBU) || (funct == F_SLT));
  assign is_ori   = (op == OP_ORI);
  assign is_addi  = (op == OP_ADDI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);

  // A request state whose counter has reached TIMEOUT spends this cycle
  // aborting the access instead of requesting.
  assign req_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                     (state_reg == S_MEMWR);
  assign timeout   = req_state && (wait_cnt_reg == TIMEOUT_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Wait counter. It restarts on every state change, and also after an abort
  // so that the retried fetch gets a fresh budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if ((state_next != state_reg) || timeout) begin
      wait_cnt_reg <= '0;
    end else if (req_state && !memAck) begin
      wait_cnt_reg <= wait_cnt_reg + CW'(1);
    end
  end

  // addi overflow latch. It is captured in EXEC and consumed in ALUWB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if ((state_reg == S_EXEC) && is_addi) begin
      ovf_reg <= overflow;
    end else if (state_reg == S_ALUWB) begin
      ovf_reg <= 1'b0;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state_reg;
    memReq     = 1'b0;
    memWr      = 1'b0;
    iorD       = 1'b0;
    irWr       = 1'b0;
    pcWr       = 1'b0;
    pcSrc      = 2'b00;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'b00;
    extOp      = 1'b0;
    aluCtr     = 3'b000;
    regWr      = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    instrDone  = 1'b0;
    illegal    = 1'b0;
    memErr     = 1'b0;
    if (timeout) begin
      memErr     = 1'b1;
      state_next = S_FETCH;
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_FETCH;
        S_FETCH: begin
          memReq  = 1'b1;
          aluSrcB = 2'b01;
          if (memAck) begin
            irWr       = 1'b1;
            pcWr       = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          aluSrcB = 2'b11;
          extOp   = 1'b1;
          if (is_rtype || is_ori || is_addi || is_lui) begin
            state_next = S_EXEC;
          end else if (is_lw || is_sw) begin
            state_next = S_MEMADR;
          end else if (is_beq) begin
            state_next = S_BRANCH;
          end else if (is_j) begin
            state_next = S_JUMP;
          end else begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_EXEC: begin
          aluSrcA = 1'b1;
          if (is_rtype) begin
            aluSrcB = 2'b00;
            if (funct == F_SUBU) begin
              aluCtr = 3'b001;
            end else if (funct == F_SLT) begin
              aluCtr = 3'b100;
            end else begin
              aluCtr = 3'b000;
            end
          end else if (is_ori) begin
            aluSrcB = 2'b10;
            aluCtr  = 3'b010;
          end else if (is_addi) begin
            aluSrcB = 2'b10;
            extOp   = 1'b1;
            aluCtr  = 3'b011;
          end else if (is_lui) begin
            aluSrcB = 2'b10;
            aluCtr  = 3'b101;
          end
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          regWr      = ~ovf_reg;
          regDst     = is_rtype;
          instrDone  = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMADR: begin
          aluSrcA    = 1'b1;
          aluSrcB    = 2'b10;
          extOp      = 1'b1;
          state_next = is_sw ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          memReq = 1'b1;
          iorD   = 1'b1;
          if (memAck) begin
            state_next = S_MEMWB;
          end
        end
        S_MEMWB: begin
          regWr      = 1'b1;
          memToReg   = 1'b1;
          instrDone  = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          memReq = 1'b1;
          iorD   = 1'b1;
          memWr  = 1'b1;
          if (memAck) begin
            instrDone  = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_BRANCH: begin
          aluSrcA    = 1'b1;
          aluCtr     = 3'b001;
          pcSrc      = 2'b01;
          pcWr       = zero;
          instrDone  = 1'b1;
          state_next = S_FETCH;
        end
        S_JUMP: begin
          pcSrc      = 2'b10;
          pcWr       = 1'b1;
          instrDone  = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. An instruction-level
// reference model expands each instruction into the control word expected
// on every cycle. Directed and random scenarios replay those cycles against
// the DUT.
module tb_mc_ctrl;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic       memReq;
    logic       memWr;
    logic       iorD;
    logic       irWr;
    logic       pcWr;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       extOp;
    logic [2:0] aluCtr;
    logic       regWr;
    logic       regDst;
    logic       memToReg;
    logic       instrDone;
    logic       illegal;
    logic       memErr;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       ack;
    logic       z;
    logic       ov;
    out_t       exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] op, funct;
  logic zero, overflow, memAck;
  logic memReq, memWr, iorD, irWr, pcWr;
  logic [1:0] pcSrc;
  logic aluSrcA;
  logic [1:0] aluSrcB;
  logic extOp;
  logic [2:0] aluCtr;
  logic regWr, regDst, memToReg, instrDone, illegal, memErr;

  int n_checks = 0;
  int n_fail = 0;
  cyc_t q[$];

  always #5 clk = ~clk;

  mc_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .overflow(overflow), .memAck(memAck), .memReq(memReq), .memWr(memWr),
    .iorD(iorD), .irWr(irWr), .pcWr(pcWr), .pcSrc(pcSrc), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .extOp(extOp), .aluCtr(aluCtr), .regWr(regWr),
    .regDst(regDst), .memToReg(memToReg), .instrDone(instrDone),
    .illegal(illegal), .memErr(memErr)
  );

  function automatic out_t sample();
    return out_t'({memReq, memWr, iorD, irWr, pcWr, pcSrc, aluSrcA, aluSrcB,
                   extOp, aluCtr, regWr, regDst, memToReg, instrDone,
                   illegal, memErr});
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [5:0] o, input logic [5:0] f, input logic a,
                      input logic z, input logic ov, input out_t e);
    cyc_t c;
    c.op = o; c.funct = f; c.ack = a; c.z = z; c.ov = ov; c.exp = e;
    q.push_back(c);
  endtask

  // One memory access. The kind is 0 for fetch, 1 for read and 2 for write.
  // The access is acknowledged after dly unacknowledged cycles. A delay of
  // TIMEOUT or more never gets an ack and ends in the abort cycle.
  task automatic model_access(input int kind, input int dly, input logic [5:0] o,
                              input logic [5:0] f, output bit ok);
    out_t e;
    for (int k = 0; k < TIMEOUT && k <= dly; k++) begin
      e = '0;
      e.memReq = 1'b1;
      e.iorD = (kind != 0);
      e.memWr = (kind == 2);
      if (kind == 0) e.aluSrcB = 2'b01;
      if (k == dly) begin
        if (kind == 0) begin e.irWr = 1'b1; e.pcWr = 1'b1; end
        if (kind == 2) e.instrDone = 1'b1;
      end
      if (kind == 0) push(6'($urandom), 6'($urandom), (k == dly), rnd(), rnd(), e);
      else push(o, f, (k == dly), rnd(), rnd(), e);
    end
    ok = (dly < TIMEOUT);
    if (!ok) begin
      e = '0;
      e.memErr = 1'b1;
      push(o, f, rnd(), rnd(), rnd(), e);
    end
  endtask

  // Expand one instruction into per-cycle expectations. force_zo >= 0 pins
  // zero (beq) or overflow (addi) in the cycle where it matters.
  task automatic model_instr(input logic [5:0] o, input logic [5:0] f, input int fdly,
                             input int mdly, input int force_zo);
    out_t e;
    bit ok;
    int kind;
    logic v, ovf;
    model_access(0, fdly, o, f, ok);
    if (!ok) model_access(0, 0, o, f, ok);
    kind = 8;
    case (o)
      6'b000000: if (f == 6'b100001 || f == 6'b100011 || f == 6'b101010) kind = 0;
      6'b001101: kind = 1;
      6'b001000: kind = 2;
      6'b001111: kind = 3;
      6'b100011: kind = 4;
      6'b101011: kind = 5;
      6'b000100: kind = 6;
      6'b000010: kind = 7;
      default: kind = 8;
    endcase
    e = '0; e.aluSrcB = 2'b11; e.extOp = 1'b1;
    if (kind == 8) begin
      e.illegal = 1'b1;
      push(o, f, rnd(), rnd(), rnd(), e);
      return;
    end
    push(o, f, rnd(), rnd(), rnd(), e);
    v = (force_zo >= 0) ? logic'(force_zo) : rnd();
    if (kind <= 3) begin
      e = '0; e.aluSrcA = 1'b1;
      case (kind)
        0: e.aluCtr = (f == 6'b100011) ? 3'b001 : (f == 6'b101010) ? 3'b100 : 3'b000;
        1: begin e.aluSrcB = 2'b10; e.aluCtr = 3'b010; end
        2: begin e.aluSrcB = 2'b10; e.extOp = 1'b1; e.aluCtr = 3'b011; end
        default: begin e.aluSrcB = 2'b10; e.aluCtr = 3'b101; end
      endcase
      push(o, f, rnd(), rnd(), v, e);
      ovf = (kind == 2) ? v : 1'b0;
      e = '0; e.regWr = !ovf; e.regDst = (kind == 0); e.instrDone = 1'b1;
      push(o, f, rnd(), rnd(), rnd(), e);
    end else if (kind <= 5) begin
      e = '0; e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.extOp = 1'b1;
      push(o, f, rnd(), rnd(), rnd(), e);
      model_access((kind == 4) ? 1 : 2, mdly, o, f, ok);
      if (ok && kind == 4) begin
        e = '0; e.regWr = 1'b1; e.memToReg = 1'b1; e.instrDone = 1'b1;
        push(o, f, rnd(), rnd(), rnd(), e);
      end
    end else if (kind == 6) begin
      e = '0; e.aluSrcA = 1'b1; e.aluCtr = 3'b001; e.pcSrc = 2'b01;
      e.pcWr = v; e.instrDone = 1'b1;
      push(o, f, rnd(), v, rnd(), e);
    end else begin
      e = '0; e.pcSrc = 2'b10; e.pcWr = 1'b1; e.instrDone = 1'b1;
      push(o, f, rnd(), rnd(), rnd(), e);
    end
  endtask

  task automatic run_cycle(input cyc_t c, output out_t act);
    @(posedge clk);
    #1;
    op = c.op; funct = c.funct; memAck = c.ack; zero = c.z; overflow = c.ov;
    @(negedge clk);
    act = sample();
  endtask

  task automatic test_reset();
    out_t a;
    rst_n = 1'b1; op = '0; funct = '0; zero = 0; overflow = 0; memAck = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = sample();
      n_checks++;
      if (a !== out_t'(0)) begin
        n_fail++;
        $display("FAIL reset cycle %0d: outputs=%h expected=%h", i, a, out_t'(0));
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    a = sample();
    n_checks++;
    if (a !== out_t'(0)) begin
      n_fail++;
      $display("FAIL reset_idle: outputs=%h expected=%h", a, out_t'(0));
    end
  endtask

  task automatic test_addu();
    cyc_t c; out_t a; int n = 0;
    model_instr(6'b000000, 6'b100001, 0, 0, -1);
    while (q.size() != 0) begin
      c = q.pop_front(); run_cycle(c, a); n_checks++;
      if (a !== c.exp) begin
        n_fail++; $display("FAIL addu cycle %0d: outputs=%h expected=%h", n, a, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_addi_overflow();
    cyc_t c; out_t a; int n = 0;
    model_instr(6'b001000, 6'($urandom), 0, 0, 1);
    model_instr(6'b001000, 6'($urandom), 0, 0, 0);
    while (q.size() != 0) begin
      c = q.pop_front(); run_cycle(c, a); n_checks++;
      if (a !== c.exp) begin
        n_fail++; $display("FAIL addi_ovf cycle %0d: outputs=%h expected=%h", n, a, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_lw_delay();
    cyc_t c; out_t a; int n = 0;
    model_instr(6'b100011, 6'($urandom), 0, 3, -1);
    model_instr(6'b101011, 6'($urandom), 2, 1, -1);
    while (q.size() != 0) begin
      c = q.pop_front(); run_cycle(c, a); n_checks++;
      if (a !== c.exp) begin
        n_fail++; $display("FAIL lw_sw_delay cycle %0d: outputs=%h expected=%h", n, a, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_beq();
    cyc_t c; out_t a; int n = 0;
    model_instr(6'b000100, 6'($urandom), 0, 0, 1);
    model_instr(6'b000100, 6'($urandom), 0, 0, 0);
    model_instr(6'b000010, 6'($urandom), 0, 0, -1);
    while (q.size() != 0) begin
      c = q.pop_front(); run_cycle(c, a); n_checks++;
      if (a !== c.exp) begin
        n_fail++; $display("FAIL beq_j cycle %0d: outputs=%h expected=%h", n, a, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_illegal_timeout();
    cyc_t c; out_t a; int n = 0;
    model_instr(6'b111111, 6'($urandom), 0, 0, -1);
    model_instr(6'b000000, 6'b100000, 0, 0, -1);
    model_instr(6'b000010, 6'($urandom), 0, 0, -1);
    model_instr(6'b001101, 6'($urandom), TIMEOUT, 0, -1);
    model_instr(6'b101011, 6'($urandom), 0, TIMEOUT + 3, -1);
    model_instr(6'b100011, 6'($urandom), 0, TIMEOUT - 1, -1);
    while (q.size() != 0) begin
      c = q.pop_front(); run_cycle(c, a); n_checks++;
      if (a !== c.exp) begin
        n_fail++; $display("FAIL illegal_timeout cycle %0d: outputs=%h expected=%h", n, a, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_random();
    cyc_t c; out_t a; int n = 0;
    logic [5:0] ops [12];
    logic [5:0] fns [12];
    int idx, fd, md;
    ops = '{6'd0, 6'd0, 6'd0, 6'b001101, 6'b001000, 6'b001111, 6'b100011,
            6'b101011, 6'b000100, 6'b000010, 6'b111111, 6'd0};
    fns = '{6'b100001, 6'b100011, 6'b101010, 6'd0, 6'd0, 6'd0, 6'd0,
            6'd0, 6'd0, 6'd0, 6'd0, 6'b100100};
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 11);
      fd = ($urandom_range(0, 19) == 0) ? TIMEOUT + 1 : $urandom_range(0, 3);
      md = ($urandom_range(0, 19) == 0) ? TIMEOUT : $urandom_range(0, 4);
      model_instr(ops[idx], (idx < 3 || idx == 11) ? fns[idx] : 6'($urandom), fd, md, -1);
    end
    while (q.size() != 0) begin
      c = q.pop_front(); run_cycle(c, a); n_checks++;
      if (a !== c.exp) begin
        n_fail++; $display("FAIL random cycle %0d: outputs=%h expected=%h", n, a, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_async_reset();
    cyc_t c; out_t a; int n = 0;
    model_instr(6'b101011, 6'($urandom), 0, 6, -1);
    for (int i = 0; i < 5; i++) begin
      c = q.pop_front(); run_cycle(c, a); n_checks++;
      if (a !== c.exp) begin
        n_fail++; $display("FAIL async_pre cycle %0d: outputs=%h expected=%h", i, a, c.exp);
      end
    end
    q.delete();
    #2 rst_n = 1'b0;
    #1 a = sample();
    n_checks++;
    if (a !== out_t'(0)) begin
      n_fail++; $display("FAIL async_drop: outputs=%h expected=%h", a, out_t'(0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    a = sample();
    n_checks++;
    if (a !== out_t'(0)) begin
      n_fail++; $display("FAIL async_idle: outputs=%h expected=%h", a, out_t'(0));
    end
    model_instr(6'b000000, 6'b101010, 1, 0, -1);
    while (q.size() != 0) begin
      c = q.pop_front(); run_cycle(c, a); n_checks++;
      if (a !== c.exp) begin
        n_fail++; $display("FAIL async_post cycle %0d: outputs=%h expected=%h", n, a, c.exp);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_addi_overflow();
    test_lw_delay();
    test_beq();
    test_illegal_timeout();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
